// File: rtl/instr_stream_writer.sv
// Streams instruction items into an 8-bit-addressed instruction memory, expanding EXT items into a prefix/body pair.
// Optional checksum output enabled by defining INSTR_STREAM_WRITER_CHECKSUM_EN.
module instr_stream_writer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] in_instr,
  input  logic       in_has_ext,
  input  logic [4:0] in_ext,
  input  logic       in_last,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       done,
  output logic       error
`ifdef INSTR_STREAM_WRITER_CHECKSUM_EN
  ,
  output logic [8:0] checksum
`endif
);

  typedef enum logic [2:0] {IDLE, RUN, BODY, DONE, ERR} state_t;

  localparam logic [3:0] EXT_PREFIX = 4'b1110;

  state_t     state, state_n;
  logic [8:0] addr, addr_n;
  logic       wr_en_n, wr_last, wr_last_n;
  logic [7:0] wr_addr_n;
  logic [8:0] wr_data_n;
  logic       done_n, error_n;
  logic [8:0] instr_q, instr_n;
  logic       last_q, last_n;
  logic       load_start;
  logic [9:0] need;
  logic       illegal, overflow;

  assign in_ready = (state == RUN);
  assign need     = {1'b0, addr} + (in_has_ext ? 10'd2 : 10'd1);
  assign illegal  = (in_instr[8:5] == EXT_PREFIX);
  assign overflow = (need > 10'd256);

  always_comb begin
    state_n    = state;
    addr_n     = addr;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    wr_last_n  = 1'b0;
    done_n     = done;
    error_n    = error;
    instr_n    = instr_q;
    last_n     = last_q;
    load_start = 1'b0;

    // done rises the cycle after the final word is on the write port
    if (wr_en && wr_last) done_n = 1'b1;

    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          load_start = 1'b1;
          state_n    = RUN;
          addr_n     = 9'd0;
          done_n     = 1'b0;
          error_n    = 1'b0;
        end
      end
      RUN: begin
        if (in_valid) begin
          if (illegal || overflow) begin
            state_n = ERR;
            error_n = 1'b1;
          end else if (in_has_ext) begin
            wr_en_n   = 1'b1;
            wr_addr_n = addr[7:0];
            wr_data_n = {EXT_PREFIX, in_ext};
            instr_n   = in_instr;
            last_n    = in_last;
            addr_n    = addr + 9'd1;
            state_n   = BODY;
          end else begin
            wr_en_n   = 1'b1;
            wr_addr_n = addr[7:0];
            wr_data_n = in_instr;
            wr_last_n = in_last;
            addr_n    = addr + 9'd1;
            state_n   = in_last ? DONE : RUN;
          end
        end
      end
      BODY: begin
        wr_en_n   = 1'b1;
        wr_addr_n = addr[7:0];
        wr_data_n = instr_q;
        wr_last_n = last_q;
        addr_n    = addr + 9'd1;
        state_n   = last_q ? DONE : RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr    <= 9'd0;
      wr_en   <= 1'b0;
      wr_addr <= 8'd0;
      wr_data <= 9'd0;
      wr_last <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      instr_q <= 9'd0;
      last_q  <= 1'b0;
    end else begin
      addr    <= addr_n;
      wr_en   <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
      wr_last <= wr_last_n;
      done    <= done_n;
      error   <= error_n;
      instr_q <= instr_n;
      last_q  <= last_n;
    end
  end

`ifdef INSTR_STREAM_WRITER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset)          checksum <= 9'd0;
    else if (load_start) checksum <= 9'd0;
    else if (wr_en)      checksum <= checksum ^ wr_data;
  end
`endif

endmodule

// File: tb/tb_instr_stream_writer.sv
// Randomized and directed bench for instr_stream_writer against a queue-based write-list model.
module tb_instr_stream_writer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_instr = 9'd0;
  logic       in_has_ext = 1'b0;
  logic [4:0] in_ext = 5'd0;
  logic       in_last = 1'b0;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [8:0] wr_data;
  logic       done;
  logic       error;
`ifdef INSTR_STREAM_WRITER_CHECKSUM_EN
  logic [8:0] checksum;
`endif

  instr_stream_writer dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_has_ext(in_has_ext), .in_ext(in_ext), .in_last(in_last),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .error(error)
`ifdef INSTR_STREAM_WRITER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [7:0] a; logic [8:0] d; } wr_t;
  typedef struct { logic [8:0] instr; bit he; logic [4:0] ext; bit last; } item_t;

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    done_cyc = -1;
  logic  done_prev = 1'b0;
  wr_t   obs[$];
  wr_t   exp_q[$];
  item_t prog[$];
  int    m_addr = 0;
  int    m_st = 0;  // 0 loading, 1 done, 2 error

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en) obs.push_back(wr_t'{cyc, wr_addr, wr_data});
    if (done && !done_prev && done_cyc < 0) done_cyc = cyc;
    done_prev = done;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: an item of n words either fits entirely below 256 or aborts the load.
  task automatic model_item(input item_t it);
    int words;
    logic [31:0] a;
    words = it.he ? 2 : 1;
    if (m_st != 0) return;
    if (it.instr[8:5] == 4'b1110 || m_addr + words > 256) begin
      m_st = 2;
    end else begin
      if (it.he) begin
        a = m_addr;
        exp_q.push_back(wr_t'{0, a[7:0], {4'b1110, it.ext}});
        m_addr++;
      end
      a = m_addr;
      exp_q.push_back(wr_t'{0, a[7:0], it.instr});
      m_addr++;
      if (it.last) m_st = 1;
    end
  endtask

  function automatic logic [8:0] legal_instr();
    logic [8:0] v;
    v = 9'($urandom);
    while (v[8:5] == 4'b1110) v = 9'($urandom);
    return v;
  endfunction

  function automatic item_t rand_item();
    item_t it;
    it.instr = 9'($urandom);
    if ($urandom_range(0, 2) != 0 && it.instr[8:5] == 4'b1110) it.instr[8] = 1'b0;
    it.he   = ($urandom_range(0, 3) == 0);
    it.ext  = 5'($urandom);
    it.last = 1'b0;
    return it;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    obs.delete();
    exp_q.delete();
    done_cyc = -1;
    m_addr = 0;
    m_st = 0;
    chk("start_done", done, 0);
    chk("start_error", error, 0);
    chk("start_ready", in_ready, 1);
  endtask

  task automatic offer(input item_t it);
    int k;
    in_valid = 1'b1; in_instr = it.instr; in_has_ext = it.he; in_ext = it.ext; in_last = it.last;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_result();
    logic [8:0] x;
    chk("wr_count", obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      chk("wr_addr", obs[i].a, exp_q[i].a);
      chk("wr_data", obs[i].d, exp_q[i].d);
    end
    chk("done", done, m_st == 1);
    chk("error", error, m_st == 2);
    chk("ready_end", in_ready, 0);
    x = 9'd0;
    foreach (exp_q[i]) x ^= exp_q[i].d;
`ifdef INSTR_STREAM_WRITER_CHECKSUM_EN
    chk("checksum", checksum, x);
`endif
  endtask

  task automatic run_prog(input bit gaps);
    int g;
    pulse_start();
    foreach (prog[i]) begin
      if (m_st != 0) break;
      model_item(prog[i]);
      offer(prog[i]);
      if (gaps) begin
        g = $urandom_range(0, 3);
        repeat (g) begin
          start = (m_st == 0) && ($urandom_range(0, 3) == 0);
          @(negedge clk);
        end
        start = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    check_result();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
`ifdef INSTR_STREAM_WRITER_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, 0);
`endif
  endtask

  initial begin
    item_t it;
    int n;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    chk("idle_ready", in_ready, 0);

    // two plain items back-to-back
    prog.delete();
    prog.push_back(item_t'{9'h012, 1'b0, 5'h00, 1'b0});
    prog.push_back(item_t'{9'h034, 1'b0, 5'h00, 1'b1});
    run_prog(1'b0);
    if (obs.size() == 2) begin
      chk("b2b_cycle", obs[1].cyc, obs[0].cyc + 1);
      chk("done_latency", done_cyc, obs[1].cyc + 1);
    end
`ifdef INSTR_STREAM_WRITER_CHECKSUM_EN
    chk("checksum_026", checksum, 9'h026);
`endif

    // EXT pair, with inputs changed right after the transfer
    pulse_start();
    it = item_t'{9'h055, 1'b1, 5'h0A, 1'b0};
    model_item(it);
    in_valid = 1'b1; in_instr = it.instr; in_has_ext = 1'b1; in_ext = it.ext; in_last = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_instr = 9'h1FF; in_ext = 5'h1F; in_has_ext = 1'b0; in_last = 1'b1;
    @(negedge clk);
    chk("ext_pre_en", wr_en, 1);
    chk("ext_pre_addr", wr_addr, 0);
    chk("ext_pre_data", wr_data, 9'h1CA);
    chk("ext_ready_low", in_ready, 0);
    @(negedge clk);
    chk("ext_body_en", wr_en, 1);
    chk("ext_body_addr", wr_addr, 1);
    chk("ext_body_data", wr_data, 9'h055);
    chk("ext_ready_back", in_ready, 1);
    it = item_t'{9'h007, 1'b0, 5'h00, 1'b1};
    model_item(it);
    offer(it);
    repeat (4) @(negedge clk);
    check_result();

    // illegal instruction collides with prefix encoding
    pulse_start();
    it = item_t'{9'h1C3, 1'b0, 5'h00, 1'b0};
    model_item(it);
    offer(it);
    repeat (3) begin
      chk("illegal_wr_en", wr_en, 0);
      chk("illegal_error", error, 1);
      chk("illegal_ready", in_ready, 0);
      @(negedge clk);
    end
    check_result();

    // reset while the body write is pending
    pulse_start();
    in_valid = 1'b1; in_instr = 9'h0AA; in_has_ext = 1'b1; in_ext = 5'h03; in_last = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_body_prefix", wr_en, 1);
    @(negedge clk);
    check_reset_outputs("rst_body");
    chk("rst_body_writes", obs.size(), 1);
    reset = 1'b1;
    @(negedge clk);
    prog.delete();
    prog.push_back(item_t'{9'h011, 1'b0, 5'h00, 1'b1});
    run_prog(1'b0);

    // 255 plain items then an EXT item -> overflow
    prog.delete();
    for (int i = 0; i < 255; i++) prog.push_back(item_t'{legal_instr(), 1'b0, 5'h00, 1'b0});
    prog.push_back(item_t'{legal_instr(), 1'b1, 5'h15, 1'b1});
    run_prog(1'b0);

    // 256 plain items ending in last -> done
    prog.delete();
    for (int i = 0; i < 256; i++) prog.push_back(item_t'{legal_instr(), 1'b0, 5'h00, i == 255});
    run_prog(1'b0);

    // 256 plain items without last, then one more -> overflow
    prog.delete();
    for (int i = 0; i < 257; i++) prog.push_back(item_t'{legal_instr(), 1'b0, 5'h00, i == 256});
    run_prog(1'b0);

    // random programs with gaps and ignored start pulses
    repeat (40) begin
      prog.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        it = rand_item();
        it.last = (i == n - 1);
        prog.push_back(it);
      end
      run_prog(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_stream_writer.md
INSTR_STREAM_WRITER -- requirements
Module: instr_stream_writer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low; sampled on rising clk edge.
REQ-003 SHALL have port: start  input  1  begin a new program load at address 0.
REQ-004 SHALL have ports: in_valid input 1 and in_ready output 1, forming the instruction-offer handshake.
REQ-005 SHALL have port: in_instr  input  9  core instruction word.
REQ-006 SHALL have port: in_has_ext  input  1  instruction carries an EXT immediate.
REQ-007 SHALL have port: in_ext  input  5  EXT payload, placed in the prefix low bits.
REQ-008 SHALL have port: in_last  input  1  offered item is the final item of the program.
REQ-009 SHALL have ports wr_en output 1, wr_addr output 8 and wr_data output 9, forming the instruction-memory write port.
REQ-010 SHALL have ports done output 1 and error output 1, giving load status.

Function
REQ-011 SHALL implement the states IDLE, RUN, BODY, DONE and ERR.
REQ-012 SHALL drive in_ready=1 only in RUN; transfer occurs on clk edge with in_valid=1 and in_ready=1.
REQ-013 SHALL leave IDLE, DONE and ERR only on start=1, moving to RUN with next address=0 and done=0, error=0 on the following cycle.
REQ-014 SHALL ignore start while in RUN or BODY.
REQ-015 SHALL handle a transfer without EXT: in cycle N+1, wr_en=1, wr_addr=addr, wr_data=in_instr, addr+1; state stays RUN; back-to-back transfers give 1 word per cycle.
REQ-016 SHALL handle a transfer with EXT as follows:
- cycle N+1: wr_en=1, wr_data={4'b1110,in_ext}, state=BODY, in_ready=0.
- cycle N+2: wr_en=1, wr_data=captured in_instr at addr+1, return to RUN.
REQ-017 SHALL capture in_instr, in_ext and in_last at transfer; later input changes SHALL NOT affect the pending write.
REQ-018 SHALL flag in_instr[8:5]==4'b1110 (collides with the EXT prefix encoding) as illegal: no write, state=ERR, error=1.
REQ-019 SHALL treat the last write of a transfer with in_last=1 as the end of the load: state=DONE and done=1 in the cycle after that write.
REQ-020 SHALL treat a transfer needing more words than remain (addr+words>256) as overflow: no write of any part, state=ERR, error=1, next cycle.
REQ-021 SHALL write a non-EXT item at addr=255 normally; if that item has in_last=0, the next transfer SHALL be overflow.
REQ-022 SHALL hold wr_en=0 in all cycles other than those in REQ-015/016; wr_addr and wr_data SHALL hold their last values when idle.
REQ-023 SHALL keep done and error mutually exclusive and sticky until start or reset.

Reset
REQ-024 SHALL, with reset=0 at a clk edge, enter IDLE and set addr=0, wr_en=0, wr_addr=0, wr_data=0, in_ready=0, done=0, error=0 and checksum=0.
REQ-025 SHALL, on reset mid-EXT pair (state BODY), drop the body write; the orphaned prefix in memory is acceptable.
REQ-026 SHALL let reset take priority over start and transfers in the same cycle.

Configuration
REQ-027 SHALL add, with macro INSTR_STREAM_WRITER_CHECKSUM_EN defined, output checksum (9 bits), the XOR of every wr_data written since the last start.
REQ-028 SHALL clear checksum on start and update it in the cycle after each write.
REQ-029 SHALL have no checksum port or logic when INSTR_STREAM_WRITER_CHECKSUM_EN is undefined; all other behaviour SHALL be identical.

Verification
REQ-030 SHALL cover: start; items 9'h012, 9'h034 (last) offered back-to-back -> writes addr0=012, addr1=034 on consecutive cycles; done=1 the next cycle.
REQ-031 SHALL cover: item in_instr=9'h055, in_has_ext=1, in_ext=5'h0A -> addr0=9'h1CA, addr1=9'h055; in_ready=0 for one cycle.
REQ-032 SHALL cover: in_instr=9'h1C3 -> no wr_en, error=1, in_ready=0 until start.
REQ-033 SHALL cover: 255 non-EXT items, then an EXT item -> no write at 255; error=1. Also: 256 non-EXT items with last -> done=1.
REQ-034 SHALL cover: reset=0 asserted while in BODY -> no body write; all outputs at reset values the next cycle.
REQ-035 SHALL cover, with INSTR_STREAM_WRITER_CHECKSUM_EN: writes 9'h012, 9'h034 -> checksum=9'h026.
